// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1/8E1/8O1 UART receiver with mid-bit sampling, a one-cycle
//               data strobe and one-cycle parity/stop error strobes.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       PAR_EN,
    input  logic       parity_type,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       par_err,
    output logic       stop_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             par_en_q;
    logic             par_type_q;
    logic             par_bad_q;
    logic [7:0]       p_data_q;
    logic             data_valid_q;
    logic             par_err_q;
    logic             stop_err_q;
    logic             busy_q;

    logic w_fall;
    logic w_at_full;

    // Synchronizer and history flops preset high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign w_fall    = rx_prev_q & ~rx_s_q;
    assign w_at_full = (cnt_q == c_FULL);
    assign cnt_d     = w_at_full ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= 8'h00;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_fall) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == c_HALF) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= S_DATA;
                            par_en_q   <= PAR_EN;
                            par_type_q <= parity_type;
                            par_bad_q  <= 1'b0;
                            bit_idx_q  <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_d;
                    if (w_at_full) begin
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_q <= cnt_d;
                    if (w_at_full) begin
                        par_bad_q <= ((^shift_q) ^ rx_s_q) != par_type_q;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_d;
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                    if (w_at_full) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (!rx_s_q) begin
                            stop_err_q <= 1'b1;
                        end else if (par_bad_q) begin
                            par_err_q <= 1'b1;
                        end else begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stop_err   = stop_err_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int c_BIT = 16;

    logic       clk;
    logic       r_rst;
    logic       r_rx;
    logic       r_par_en;
    logic       r_par_type;
    logic [7:0] w_p_data;
    logic       w_data_valid;
    logic       w_par_err;
    logic       w_stop_err;
    logic       w_busy;

    int         n_checks;
    int         n_errors;
    int         n_valid;
    int         n_perr;
    int         n_serr;
    logic [7:0] r_log [0:15];
    logic       r_busy_mid;
    int         b_valid;
    int         b_perr;
    int         b_serr;

    uart_rx #(
        .CLKS_PER_BIT(c_BIT),
        .CNT_W       (16)
    ) u_dut (
        .clk        (clk),
        .rst        (r_rst),
        .rx_in      (r_rx),
        .PAR_EN     (r_par_en),
        .parity_type(r_par_type),
        .p_data     (w_p_data),
        .data_valid (w_data_valid),
        .par_err    (w_par_err),
        .stop_err   (w_stop_err),
        .busy       (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every high cycle of a strobe is counted, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (w_data_valid) begin
            r_log[n_valid[3:0]] <= w_p_data;
            n_valid             <= n_valid + 1;
        end
        if (w_par_err)  n_perr <= n_perr + 1;
        if (w_stop_err) n_serr <= n_serr + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_perr  = n_perr;
        b_serr  = n_serr;
    endtask

    task automatic check_pulses(input string tag, input int dv, input int dp, input int ds);
        check_eq({tag, "_valid"}, n_valid - b_valid, dv);
        check_eq({tag, "_perr"},  n_perr - b_perr,   dp);
        check_eq({tag, "_serr"},  n_serr - b_serr,   ds);
    endtask

    // Line is left at the stop-bit level when the task returns.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit sbit);
        r_rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        r_busy_mid = w_busy;
        for (int i = 0; i < 8; i++) begin
            r_rx = d[i];
            repeat (c_BIT) @(negedge clk);
        end
        if (pen) begin
            r_rx = pbit;
            repeat (c_BIT) @(negedge clk);
        end
        r_rx = sbit;
        repeat (c_BIT) @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_valid    = 0;
        n_perr     = 0;
        n_serr     = 0;
        r_busy_mid = 1'b0;
        r_rst      = 1'b0;
        r_rx       = 1'b1;
        r_par_en   = 1'b0;
        r_par_type = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_p_data", w_p_data, 8'h00);
        check_eq("rst_busy", w_busy, 1'b0);
        check_eq("rst_flags", {w_data_valid, w_par_err, w_stop_err}, 3'b000);
        r_rst = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check_pulses("n81", 1, 0, 0);
        check_eq("n81_data", w_p_data, 8'hA5);
        check_eq("n81_busy_mid", r_busy_mid, 1'b1);
        check_eq("n81_busy_end", w_busy, 1'b0);

        // Even parity: 0x3C has four ones, so parity bit 0 is good and 1 is bad.
        r_par_en   = 1'b1;
        r_par_type = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check_pulses("even_ok", 1, 0, 0);
        check_eq("even_ok_data", w_p_data, 8'h3C);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        check_pulses("even_bad", 0, 1, 0);
        check_eq("even_bad_data", w_p_data, 8'h3C);

        // Odd parity: 0x01 has one one, so parity bit 0 is good; config flipped mid-frame.
        r_par_type = 1'b1;
        snap();
        fork
            send_frame(8'h01, 1'b1, 1'b0, 1'b1);
            begin
                repeat (4 * c_BIT) @(negedge clk);
                r_par_type = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        check_pulses("odd_ok", 1, 0, 0);
        check_eq("odd_ok_data", w_p_data, 8'h01);
        r_par_type = 1'b1;
        r_par_en   = 1'b0;

        // Glitch: 4 clocks low is shorter than half a bit.
        snap();
        r_rx = 1'b0;
        repeat (4) @(negedge clk);
        r_rx = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("glitch_busy_mid", w_busy, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("glitch_busy_end", w_busy, 1'b0);
        check_pulses("glitch", 0, 0, 0);

        // Stop bit low on 0xFF, then line held low for 40 bit times.
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check_pulses("stop_err", 0, 0, 1);
        check_eq("stop_err_data", w_p_data, 8'h01);
        snap();
        repeat (40 * c_BIT) @(negedge clk);
        check_eq("held_low_busy", w_busy, 1'b0);
        check_pulses("held_low", 0, 0, 0);
        r_rx = 1'b1;
        repeat (2 * c_BIT) @(negedge clk);
        snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check_pulses("recover", 1, 0, 0);
        check_eq("recover_data", w_p_data, 8'h5A);

        // Back-to-back frames with no idle gap.
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check_eq("b2b_count", n_valid - b_valid, 2);
        check_eq("b2b_first", r_log[b_valid[3:0]], 8'h55);
        check_eq("b2b_second", r_log[b_valid[3:0] + 4'd1], 8'hAA);

        // Back-to-back again, reset asserted three bits into the second frame.
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        snap();
        r_rx = 1'b0;
        repeat (3 * c_BIT) @(negedge clk);
        check_eq("abort_busy_before", w_busy, 1'b1);
        r_rst = 1'b0;
        #1;
        check_eq("abort_busy", w_busy, 1'b0);
        check_eq("abort_p_data", w_p_data, 8'h00);
        check_eq("abort_flags", {w_data_valid, w_par_err, w_stop_err}, 3'b000);
        repeat (3) @(negedge clk);
        r_rx  = 1'b1;
        r_rst = 1'b1;
        repeat (12 * c_BIT) @(negedge clk);
        check_pulses("abort", 0, 0, 0);
        check_eq("abort_idle_busy", w_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
